fft_frame_ctrl: RTL and testbench

//  Frame sequencer and result monitor for the streaming FFT core. Gates the ADC sample

---
 rtl/fft_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer and output-stream monitor for the streaming FFT core.
// Define FFT_CTRL_PEAK_EN to build the per-frame peak-magnitude tracker.
module fft_frame_ctrl #(
  parameter int unsigned FFT_LEN = 1024,
  parameter int unsigned DW      = 12,
  parameter int unsigned AW      = 25,
  parameter int unsigned LOG2N   = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             sample_valid,
  input  logic [DW-1:0]    sample_data,
  output logic             sample_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [DW-1:0]    sink_real,
  input  logic             sink_ready,
  input  logic             source_valid,
  input  logic             source_sop,
  input  logic             source_eop,
  input  logic [1:0]       source_error,
  input  logic [AW-1:0]    amp,
  output logic             busy,
  output logic [LOG2N-1:0] bin_idx,
  output logic             frame_done,
  output logic [LOG2N-1:0] peak_bin,
  output logic [AW-1:0]    peak_amp,
  output logic             err
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_OUT} state_t;

  state_t           state;
  logic [LOG2N-1:0] in_cnt;
  logic             stop_pend;
  logic             cont_q;
  logic             in_frame;
  logic             in_beat;
  logic [LOG2N-1:0] cur_bin;
  logic             err_set;

  // Sample path is a zero-latency gate onto the core's sink port.
  assign sink_valid   = (state == LOAD) && sample_valid;
  assign sample_ready = (state == LOAD) && sink_ready;
  assign sink_sop     = (state == LOAD) && (in_cnt == '0);
  assign sink_eop     = (state == LOAD) && (in_cnt == LAST_IDX);
  assign sink_real    = sample_data;
  assign in_beat      = sink_valid && sink_ready;
  assign busy         = (state != IDLE);

  // Index of the beat on the source port this cycle.
  assign cur_bin = source_sop ? '0 : bin_idx + LOG2N'(1);
  assign err_set = source_valid && ((source_error != 2'b00) ||
                                    (source_eop && (cur_bin != LAST_IDX)) ||
                                    (source_sop && in_frame));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      in_cnt     <= '0;
      stop_pend  <= 1'b0;
      cont_q     <= 1'b0;
      bin_idx    <= '0;
      in_frame   <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= source_valid && source_eop;
      if (source_valid) begin
        bin_idx <= cur_bin;
        if (source_eop)      in_frame <= 1'b0;
        else if (source_sop) in_frame <= 1'b1;
      end

      if (err_set)                       err <= 1'b1;
      else if (state == IDLE && start)   err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            cont_q    <= cont;
            stop_pend <= stop;
            in_cnt    <= '0;
          end
        end
        LOAD: begin
          if (stop) stop_pend <= 1'b1;
          if (in_beat) begin
            in_cnt <= in_cnt + LOG2N'(1);
            // Frame boundary decides between another frame and draining.
            if ((in_cnt == LAST_IDX) && (stop_pend || !cont_q)) begin
              state     <= WAIT_OUT;
              stop_pend <= 1'b0;
            end
          end
        end
        WAIT_OUT: begin
          if (frame_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_CTRL_PEAK_EN
  localparam logic [LOG2N-1:0] HALF_IDX = LOG2N'(FFT_LEN / 2);

  logic [AW-1:0]    run_amp, base_amp, nxt_amp;
  logic [LOG2N-1:0] run_bin, base_bin, nxt_bin;
  logic             take;

  // Running maximum over bins 1..N/2-1; a sop beat restarts the search.
  always_comb begin
    base_amp = source_sop ? '0 : run_amp;
    base_bin = source_sop ? LOG2N'(1) : run_bin;
    take     = (cur_bin != '0) && (cur_bin < HALF_IDX) && (amp > base_amp);
    nxt_amp  = take ? amp : base_amp;
    nxt_bin  = take ? cur_bin : base_bin;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      run_amp  <= '0;
      run_bin  <= LOG2N'(1);
      peak_amp <= '0;
      peak_bin <= '0;
    end else if (source_valid) begin
      if (source_eop) begin
        peak_amp <= nxt_amp;
        peak_bin <= nxt_bin;
        run_amp  <= '0;
        run_bin  <= LOG2N'(1);
      end else begin
        run_amp <= nxt_amp;
        run_bin <= nxt_bin;
      end
    end
  end
`else
  logic unused_amp;
  assign unused_amp = ^amp;
  assign peak_bin   = '0;
  assign peak_amp   = '0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomised and directed bench for fft_frame_ctrl against a behavioural frame model.
module tb_fft_frame_ctrl;
  localparam int unsigned N  = 16;
  localparam int unsigned LG = 4;
  localparam int unsigned DW = 12;
  localparam int unsigned AW = 25;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 0, stop = 0, cont = 0;
  logic          sample_valid = 0;
  logic [DW-1:0] sample_data = '0;
  logic          sink_ready = 0;
  logic          source_valid = 0, source_sop = 0, source_eop = 0;
  logic [1:0]    source_error = '0;
  logic [AW-1:0] amp = '0;
  logic          sample_ready, sink_valid, sink_sop, sink_eop;
  logic [DW-1:0] sink_real;
  logic          busy, frame_done, err;
  logic [LG-1:0] bin_idx, peak_bin;
  logic [AW-1:0] peak_amp;

  fft_frame_ctrl #(.FFT_LEN(N), .DW(DW), .AW(AW), .LOG2N(LG)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop), .cont(cont),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real),
    .sink_ready(sink_ready), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_error(source_error), .amp(amp), .busy(busy),
    .bin_idx(bin_idx), .frame_done(frame_done), .peak_bin(peak_bin), .peak_amp(peak_amp),
    .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 idle, 1 loading, 2 waiting for output frame
  int     m_state, m_pos, m_bin, m_pb, idx, pb;
  bit     m_stop, m_cont, m_fd, m_err, m_inf, m_valid = 0, nfd, e, in_beat, last;
  longint m_pa, pa;
  longint frame_amp[N];

  always @(negedge sys_clk) begin
    if (m_valid) begin
      chk("sink_valid", sink_valid, (m_state == 1) && sample_valid);
      chk("sample_ready", sample_ready, (m_state == 1) && sink_ready);
      chk("sink_sop", sink_sop, (m_state == 1) && (m_pos == 0));
      chk("sink_eop", sink_eop, (m_state == 1) && (m_pos == N - 1));
      chk("sink_real", sink_real, sample_data);
      chk("busy", busy, m_state != 0);
      chk("bin_idx", bin_idx, m_bin);
      chk("frame_done", frame_done, m_fd);
      chk("err", err, m_err);
      chk("peak_bin", peak_bin, m_pb);
      chk("peak_amp", peak_amp, m_pa);
    end
    if (sys_rst) begin
      m_state = 0; m_pos = 0; m_bin = 0; m_pb = 0; m_pa = 0;
      m_stop = 0; m_cont = 0; m_fd = 0; m_err = 0; m_inf = 0; m_valid = 1;
      foreach (frame_amp[i]) frame_amp[i] = 0;
    end else begin
      nfd = 0;
      e   = 0;
      if (source_valid) begin
        idx = source_sop ? 0 : (m_bin + 1) % N;
        e = (source_error != 0) || (source_eop && idx != N - 1) || (source_sop && m_inf);
        if (source_sop) foreach (frame_amp[i]) frame_amp[i] = 0;
        frame_amp[idx] = amp;
        if (source_eop) begin
          pb = 1; pa = 0;
          for (int b = 1; b < N / 2; b++)
            if (frame_amp[b] > pa) begin pa = frame_amp[b]; pb = b; end
`ifdef FFT_CTRL_PEAK_EN
          m_pb = pb; m_pa = pa;
`endif
          foreach (frame_amp[i]) frame_amp[i] = 0;
          nfd = 1;
        end
        if (source_eop)      m_inf = 0;
        else if (source_sop) m_inf = 1;
        m_bin = idx;
      end
      if (e) m_err = 1;
      else if (m_state == 0 && start) m_err = 0;
      in_beat = (m_state == 1) && sample_valid && sink_ready;
      case (m_state)
        0: if (start) begin m_state = 1; m_cont = cont; m_stop = stop; m_pos = 0; end
        1: begin
          last = in_beat && (m_pos == N - 1);
          if (last && (m_stop || !m_cont)) begin m_state = 2; m_stop = 0; end
          else if (stop) m_stop = 1;
          if (in_beat) m_pos = (m_pos + 1) % N;
        end
        default: if (m_fd) m_state = 0;
      endcase
      m_fd = nfd;
    end
  end

  logic [AW-1:0] pat [N];

  task automatic step();
    @(posedge sys_clk); #1;
    start = 0; stop = 0;
  endtask

  task automatic ostep();
    @(posedge sys_clk); #1;
  endtask

  task automatic out_frame(input int eop_at, input bit rnd);
    for (int b = 0; b <= eop_at; b++) begin
      if (rnd) while ($urandom % 4 == 0) begin source_valid = 0; ostep(); end
      source_valid = 1;
      source_sop   = (b == 0) || (rnd && b > 0 && $urandom % 30 == 0);
      source_eop   = (b == eop_at);
      source_error = (rnd && $urandom % 40 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      amp          = rnd ? AW'($urandom_range(0, 50)) : pat[b];
      ostep();
    end
    source_valid = 0; source_sop = 0; source_eop = 0; source_error = '0;
  endtask

  bit out_run;

  initial begin
    foreach (pat[i]) pat[i] = '0;
    repeat (2) step();
    sys_rst = 0;
    @(negedge sys_clk);
    chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    chk("rst_frame_done", frame_done, 0); chk("rst_peak_bin", peak_bin, 0);

    // Single frame, free-flowing
    start = 1; cont = 0; sample_valid = 1; sink_ready = 1;
    step();
    for (int i = 0; i < N; i++) begin
      sample_data = DW'(i);
      @(negedge sys_clk);
      chk("single_sop", sink_sop, i == 0); chk("single_eop", sink_eop, i == N - 1);
      chk("single_busy", busy, 1);
      step();
    end
    @(negedge sys_clk);
    chk("wait_out_busy", busy, 1); chk("wait_out_sink_valid", sink_valid, 0);
    pat[0] = 2000; pat[5] = 900; pat[12] = 5000;
    out_frame(N - 1, 0);
    @(negedge sys_clk);
    chk("peak_frame_done", frame_done, 1);
`ifdef FFT_CTRL_PEAK_EN
    chk("peak_bin_lit", peak_bin, 5); chk("peak_amp_lit", peak_amp, 900);
`else
    chk("peak_bin_lit", peak_bin, 0); chk("peak_amp_lit", peak_amp, 0);
`endif
    step();
    @(negedge sys_clk);
    chk("single_idle", busy, 0);

    // Back-pressure on beats 3-5
    start = 1;
    step();
    for (int c = 0; c < N + 3; c++) begin
      sink_ready = !(c >= 3 && c <= 5);
      @(negedge sys_clk);
      if (c >= 3 && c <= 5) chk("bp_ready_low", sample_ready, 0);
      if (c == N + 2) chk("bp_eop_16th", sink_eop, 1);
      step();
    end
    sink_ready = 1;
    out_frame(N - 1, 1);
    repeat (2) step();

    // Continuous mode, stop inside frame 2
    cont = 1; start = 1;
    step();
    for (int c = 0; c < 2 * N; c++) begin
      if (c == N + 7) stop = 1;
      step();
    end
    @(negedge sys_clk);
    chk("cont_no_frame3", sink_valid, 0); chk("cont_wait_busy", busy, 1);
    cont = 0;
    out_frame(N - 1, 1);
    repeat (2) step();
    @(negedge sys_clk);
    chk("cont_idle", busy, 0);

    // Early eop, sticky err, start clears, error code, reset mid-LOAD
    out_frame(9, 0);
    @(negedge sys_clk);
    chk("eop9_err", err, 1);
    repeat (3) step();
    @(negedge sys_clk);
    chk("eop9_sticky", err, 1);
    sample_valid = 0; start = 1;
    step();
    @(negedge sys_clk);
    chk("start_clears_err", err, 0);
    sample_valid = 1;
    repeat (5) step();
    source_valid = 1; source_error = 2'b01; amp = 7;
    step();
    source_valid = 0; source_error = 2'b00;
    @(negedge sys_clk);
    chk("src_error_err", err, 1);
    sys_rst = 1;
    step();
    sys_rst = 0;
    @(negedge sys_clk);
    chk("rst_mid_sink_valid", sink_valid, 0); chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0); chk("rst_mid_bin", bin_idx, 0);
    chk("rst_mid_ready", sample_ready, 0);

    // Randomised traffic on both sides
    out_run = 1;
    fork
      begin
        while (out_run) begin
          out_frame(($urandom % 5 == 0) ? $urandom_range(1, N - 2) : N - 1, 1);
          repeat ($urandom_range(0, 6)) ostep();
        end
      end
      begin
        for (int c = 0; c < 4000; c++) begin
          start        = ($urandom % 20 == 0);
          stop         = ($urandom % 25 == 0);
          cont         = 1'($urandom);
          sample_valid = ($urandom % 4 != 0);
          sink_ready   = ($urandom % 5 != 0);
          sample_data  = DW'($urandom);
          sys_rst      = ($urandom % 700 == 0);
          step();
        end
        sys_rst = 0;
        out_run = 0;
      end
    join
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
